regfile_mp_sb: RTL

//  Parametrised multi-read-port register file: the next generation of the core GPR array.
//  - Adds hardware clear after reset, write-to-read bypass and a per-register pending

---
 rtl/regfile_mp_sb.sv | 138 +++++++++++++
 1 files changed

// File: rtl/regfile_mp_sb.sv
// Purpose: multi-read-port GPR array with clear after reset, write-to-read bypass and a pending scoreboard.
// Latency: reads and rpend are combinational (0 cycles); writes and marks take effect at the next posedge.
// Backpressure: none; writes arriving before the array is initialised are dropped and flagged on wr_drop.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset; restarts the hardware clear
//   wen/waddr/wdata   writeback port
//   raddr      NUM_RD packed read indices, port i = [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata      NUM_RD packed read data,    port i = [i*DATA_WIDTH +: DATA_WIDTH]
//   rpend      per-port pending flag of the addressed register
//   mark_en/mark_addr  issue-side mark of a register as pending
//   ready      array initialised, reads and writes valid
//   wr_drop    one-cycle pulse: a write was dropped in the previous cycle
module regfile_mp_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wen,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]     raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]     rdata,
  output logic [NUM_RD-1:0]                rpend,
  input  logic                             mark_en,
  input  logic [ADDR_WIDTH-1:0]            mark_addr,
  output logic                             ready,
  output logic                             wr_drop
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_ptr;
  logic [DATA_WIDTH-1:0]   rf [DEPTH];
  logic [DEPTH-1:0]        pending;

  logic waddr_ok;
  logic mark_addr_ok;
  logic wr_commit;
  logic mark_set;

  // Entry 0 is hard-wired when ZERO_REG is set: never written, never pending.
  assign waddr_ok     = (ZERO_REG == 0) || (waddr != '0);
  assign mark_addr_ok = (ZERO_REG == 0) || (mark_addr != '0);

  // rst aborts anything presented in the same cycle.
  assign wr_commit = wen && ready && !rst && waddr_ok;
  assign mark_set  = mark_en && ready && !rst && mark_addr_ok;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    // The last entry is cleared on the same edge that moves us to READY.
    if (state == S_CLEAR && clr_ptr == LAST_IDX) state_nxt = S_READY;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready = (state == S_READY);
  end

  // ---------------- clear pointer ----------------
  always_ff @(posedge clk) begin
    if (rst)                     clr_ptr <= '0;
    else if (state == S_CLEAR)   clr_ptr <= clr_ptr + 1'b1;
  end

  // ---------------- storage ----------------
  // No reset on the array itself: the CLEAR sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) rf[clr_ptr] <= '0;
      else if (wr_commit)   rf[waddr]   <= wdata;
    end
  end

  // ---------------- scoreboard ----------------
  // Mark is applied after the clear so a same-index write+mark leaves the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (wr_commit) pending[waddr]     <= 1'b0;
      if (mark_set)  pending[mark_addr] <= 1'b1;
    end
  end

  // ---------------- dropped-write flag ----------------
  always_ff @(posedge clk) begin
    if (rst) wr_drop <= 1'b0;
    else     wr_drop <= wen && !ready;
  end

  // ---------------- read ports ----------------
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;

    assign ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd = '0;
      if (!ready) begin
        rd = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
      end else if ((BYPASS != 0) && wen && (waddr == ra)) begin
        rd = wdata;
      end else begin
        rd = rf[ra];
      end
    end

    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd;
    // Registered view only: a same-cycle write does not clear this early.
    assign rpend[i] = pending[ra];
  end

endmodule
